// File: rtl/xbus_interconnect_pkg.sv
// xbus_interconnect_pkg: shared bus widths, default slave count and FSM state encoding
package xbus_interconnect_pkg;
  localparam int XBUS_AW = 32;
  localparam int XBUS_DW = 32;
  localparam int XBUS_BEW = 4;
  localparam int XBUS_NSLAVES = 4;
  typedef enum logic [1:0] {
    XBUS_ST_IDLE   = 2'd0,
    XBUS_ST_ACCESS = 2'd1,
    XBUS_ST_RESP   = 2'd2
  } xbus_state_t;
endpackage

// File: rtl/xbus_interconnect_addr_decode.sv
// xbus_interconnect_addr_decode: combinational base/mask window decoder, lowest index wins
// Ports:
//   addr - request address
//   hit  - address falls in at least one slave window
//   sel  - one-hot select of the lowest hitting slave (zero on miss)
//   idx  - binary index of the lowest hitting slave (zero on miss)
module xbus_interconnect_addr_decode
  import xbus_interconnect_pkg::*;
#(
  parameter int NSLAVES = XBUS_NSLAVES,
  parameter int IW = 2,
  parameter logic [NSLAVES*32-1:0] SLAVE_BASE = {NSLAVES{32'h0}},
  parameter logic [NSLAVES*32-1:0] SLAVE_MASK = {NSLAVES{32'hFFFF_0000}}
) (
  input  logic [XBUS_AW-1:0] addr,
  output logic               hit,
  output logic [NSLAVES-1:0] sel,
  output logic [IW-1:0]      idx
);
  // Scanning from the top index down lets the lowest hitting index overwrite the rest.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    idx = '0;
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      if ((addr & SLAVE_MASK[32*i+:32]) == (SLAVE_BASE[32*i+:32] & SLAVE_MASK[32*i+:32])) begin
        hit = 1'b1;
        idx = IW'(i);
        sel = '0;
        sel[i] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/xbus_interconnect.sv
// xbus_interconnect: single-master / N-slave bus with registered request path and error response
// Ports:
//   clk, rst (sync, active-low)
//   m_as/m_we/m_be/m_addr/m_wdata - master request, m_as held until m_ready
//   m_rdata/m_ready/m_err         - registered one-cycle response, m_err flags miss/timeout
//   s_cs/s_we/s_be/s_addr/s_wdata - registered slave request, s_cs one-hot
//   s_rdata/s_ready               - packed per-slave read data and completion
// Optional: define XBUS_TIMEOUT_EN to abort accesses after TIMEOUT_CYC ACCESS cycles.
module xbus_interconnect
  import xbus_interconnect_pkg::*;
#(
  parameter int NSLAVES = XBUS_NSLAVES,
  parameter logic [NSLAVES*32-1:0] SLAVE_BASE = {NSLAVES{32'h0}},
  parameter logic [NSLAVES*32-1:0] SLAVE_MASK = {NSLAVES{32'hFFFF_0000}},
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       m_as,
  input  logic                       m_we,
  input  logic [XBUS_BEW-1:0]        m_be,
  input  logic [XBUS_AW-1:0]         m_addr,
  input  logic [XBUS_DW-1:0]         m_wdata,
  output logic [XBUS_DW-1:0]         m_rdata,
  output logic                       m_ready,
  output logic                       m_err,
  output logic [NSLAVES-1:0]         s_cs,
  output logic                       s_we,
  output logic [XBUS_BEW-1:0]        s_be,
  output logic [XBUS_AW-1:0]         s_addr,
  output logic [XBUS_DW-1:0]         s_wdata,
  input  logic [NSLAVES*XBUS_DW-1:0] s_rdata,
  input  logic [NSLAVES-1:0]         s_ready
);
  localparam int IW = NSLAVES > 1 ? $clog2(NSLAVES) : 1;
  xbus_state_t state_d, state_q;
  logic [IW-1:0] sel_d, sel_q;
  logic [NSLAVES-1:0] cs_d, cs_q;
  logic we_d, we_q, ready_d, ready_q, err_d, err_q;
  logic [XBUS_BEW-1:0] be_d, be_q;
  logic [XBUS_AW-1:0] addr_d, addr_q;
  logic [XBUS_DW-1:0] wdata_d, wdata_q, rdata_d, rdata_q;
  logic dec_hit;
  logic [NSLAVES-1:0] dec_sel;
  logic [IW-1:0] dec_idx;
`ifdef XBUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC) > 8 ? $clog2(TIMEOUT_CYC) : 8;
  logic [CW-1:0] cnt_d, cnt_q;
`endif
  xbus_interconnect_addr_decode #(
    .NSLAVES(NSLAVES), .IW(IW), .SLAVE_BASE(SLAVE_BASE), .SLAVE_MASK(SLAVE_MASK)
  ) u_dec (
    .addr(m_addr), .hit(dec_hit), .sel(dec_sel), .idx(dec_idx)
  );
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    cs_d = cs_q;
    we_d = we_q;
    be_d = be_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d = 1'b0;
`ifdef XBUS_TIMEOUT_EN
    cnt_d = cnt_q;
`endif
    if (state_q == XBUS_ST_IDLE && m_as) begin
      we_d = m_we;
      be_d = m_be;
      addr_d = m_addr;
      wdata_d = m_wdata;
      sel_d = dec_idx;
      cs_d = dec_sel;
      state_d = dec_hit ? XBUS_ST_ACCESS : XBUS_ST_RESP;
      ready_d = !dec_hit;
      err_d = !dec_hit;
      rdata_d = dec_hit ? rdata_q : '0;
`ifdef XBUS_TIMEOUT_EN
      cnt_d = '0;
`endif
    end else if (state_q == XBUS_ST_ACCESS) begin
      // Only the selected slave's ready counts; a ready arriving on the timeout cycle still wins.
      if (s_ready[sel_q]) begin
        rdata_d = s_rdata[{sel_q, 5'b0}+:XBUS_DW];
        ready_d = 1'b1;
        cs_d = '0;
        state_d = XBUS_ST_RESP;
      end
`ifdef XBUS_TIMEOUT_EN
      else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
        rdata_d = '0;
        ready_d = 1'b1;
        err_d = 1'b1;
        cs_d = '0;
        state_d = XBUS_ST_RESP;
      end else
        cnt_d = cnt_q + CW'(1);
`endif
    end else if (state_q == XBUS_ST_RESP)
      state_d = XBUS_ST_IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= XBUS_ST_IDLE;
      sel_q <= '0;
      cs_q <= '0;
      we_q <= 1'b0;
      be_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q <= 1'b0;
`ifdef XBUS_TIMEOUT_EN
      cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      cs_q <= cs_d;
      we_q <= we_d;
      be_q <= be_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q <= err_d;
`ifdef XBUS_TIMEOUT_EN
      cnt_q <= cnt_d;
`endif
    end
  end
  assign m_rdata = rdata_q;
  assign m_ready = ready_q;
  assign m_err = err_q;
  assign s_cs = cs_q;
  assign s_we = we_q;
  assign s_be = be_q;
  assign s_addr = addr_q;
  assign s_wdata = wdata_q;
endmodule

// File: tb/tb_xbus_interconnect.sv
// tb_xbus_interconnect: directed table-driven bench for xbus_interconnect
module tb_xbus_interconnect;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic m_as = 1'b0;
  logic m_we = 1'b0;
  logic [3:0] m_be = '0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_rdata;
  logic m_ready, m_err;
  logic [3:0] s_cs;
  logic s_we;
  logic [3:0] s_be;
  logic [31:0] s_addr, s_wdata;
  logic [127:0] s_rdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
  logic [3:0] s_ready = '0;
  int tests = 0;
  int fails = 0;
  typedef struct {
    string nm;
    logic [31:0] addr;
    logic we;
    logic [3:0] be;
    logic [31:0] wdata;
    int dly;
    logic [3:0] cs;
    logic [31:0] rdata;
    logic err;
    int lat;
  } vec_t;
  vec_t vecs[7];
  xbus_interconnect #(
    .NSLAVES(4),
    .SLAVE_BASE({32'h1000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
    .SLAVE_MASK({32'hFFFF_FF00, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000}),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst(rst), .m_as(m_as), .m_we(m_we), .m_be(m_be), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ready(m_ready), .m_err(m_err),
    .s_cs(s_cs), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ready(s_ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic run(input vec_t v);
    int n = 0;
    bit done = 0;
    @(negedge clk);
    m_as = 1'b1;
    m_we = v.we;
    m_be = v.be;
    m_addr = v.addr;
    m_wdata = v.wdata;
    s_ready = '0;
    while (!done && n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        chk({v.nm, "/s_addr"}, s_addr, v.addr);
        chk({v.nm, "/s_we"}, 32'(s_we), 32'(v.we));
        chk({v.nm, "/s_be"}, 32'(s_be), 32'(v.be));
        chk({v.nm, "/s_wdata"}, s_wdata, v.wdata);
        m_as = 1'b0;
        m_addr = 32'hFFFF_FFFF;
      end
      if (m_ready) done = 1;
      else begin
        chk({v.nm, "/cs_held"}, 32'(s_cs), 32'(v.cs));
        s_ready = (n - 1 >= v.dly) ? 4'hF : 4'h0;
      end
    end
    chk({v.nm, "/ready_seen"}, 32'(done), 32'd1);
    chk({v.nm, "/latency"}, 32'(n), 32'(v.lat));
    chk({v.nm, "/err"}, 32'(m_err), 32'(v.err));
    chk({v.nm, "/rdata"}, m_rdata, v.rdata);
    chk({v.nm, "/cs_dropped"}, 32'(s_cs), 32'd0);
    s_ready = '0;
    @(posedge clk);
    #1;
    chk({v.nm, "/ready_pulse"}, 32'(m_ready), 32'd0);
    chk({v.nm, "/err_clear"}, 32'(m_err), 32'd0);
    chk({v.nm, "/rdata_hold"}, m_rdata, v.rdata);
  endtask
  initial begin
    vecs[0] = '{"rd_s0", 32'h0000_0010, 1'b0, 4'hF, 32'h0, 0, 4'b0001, 32'hDEAD_BEEF, 1'b0, 2};
    vecs[1] = '{"wr_s2", 32'h2000_0000, 1'b1, 4'b0011, 32'h1234_5678, 3, 4'b0100, 32'h2222_2222, 1'b0, 5};
    vecs[2] = '{"miss_f", 32'hF000_0000, 1'b0, 4'hF, 32'h0, 0, 4'b0000, 32'h0, 1'b1, 1};
    vecs[3] = '{"overlap", 32'h1000_0040, 1'b0, 4'hF, 32'h0, 0, 4'b0010, 32'h1111_1111, 1'b0, 2};
    vecs[4] = '{"s0_top", 32'h0000_FFFC, 1'b0, 4'b1000, 32'h0, 1, 4'b0001, 32'hDEAD_BEEF, 1'b0, 3};
    vecs[5] = '{"s0_past", 32'h0001_0000, 1'b1, 4'hF, 32'hA5A5_A5A5, 0, 4'b0000, 32'h0, 1'b1, 1};
    vecs[6] = '{"miss_gap", 32'h1001_0000, 1'b0, 4'hF, 32'h0, 0, 4'b0000, 32'h0, 1'b1, 1};
    repeat (3) @(posedge clk);
    #1;
    chk("rst/m_rdata", m_rdata, 32'h0);
    chk("rst/m_ready", 32'(m_ready), 32'd0);
    chk("rst/m_err", 32'(m_err), 32'd0);
    chk("rst/s_cs", 32'(s_cs), 32'd0);
    chk("rst/s_addr", s_addr, 32'h0);
    chk("rst/s_wdata", s_wdata, 32'h0);
    chk("rst/s_be_we", 32'({s_be, s_we}), 32'd0);
    rst = 1'b1;
    foreach (vecs[i]) run(vecs[i]);
    // Non-selected slave ready must not complete the access.
    @(negedge clk);
    m_as = 1'b1;
    m_we = 1'b0;
    m_addr = 32'h1000_0040;
    @(posedge clk);
    #1;
    m_as = 1'b0;
    chk("pulse3/cs", 32'(s_cs), 32'b0010);
    s_ready = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("pulse3/no_ready", 32'(m_ready), 32'd0);
      chk("pulse3/cs_held", 32'(s_cs), 32'b0010);
    end
    s_ready = 4'b0010;
    @(posedge clk);
    #1;
    s_ready = '0;
    chk("pulse3/ready", 32'(m_ready), 32'd1);
    chk("pulse3/rdata", m_rdata, 32'h1111_1111);
    chk("pulse3/err", 32'(m_err), 32'd0);
    @(posedge clk);
    #1;
    // Reset in the middle of an access aborts silently.
    @(negedge clk);
    m_as = 1'b1;
    m_addr = 32'h1000_0000;
    @(posedge clk);
    #1;
    m_as = 1'b0;
    chk("rstmid/cs", 32'(s_cs), 32'b0010);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("rstmid/cs_clear", 32'(s_cs), 32'd0);
    chk("rstmid/no_ready", 32'(m_ready), 32'd0);
    chk("rstmid/rdata", m_rdata, 32'h0);
    chk("rstmid/s_addr", s_addr, 32'h0);
    run(vecs[0]);
`ifdef XBUS_TIMEOUT_EN
    run('{"timeout", 32'h2000_0000, 1'b0, 4'hF, 32'h0, 1000, 4'b0100, 32'h0, 1'b1, 17});
`else
    begin
      int seen = 0;
      @(negedge clk);
      m_as = 1'b1;
      m_addr = 32'h2000_0000;
      @(posedge clk);
      #1;
      m_as = 1'b0;
      for (int i = 0; i < 300; i++) begin
        @(posedge clk);
        #1;
        if (m_ready) seen++;
      end
      chk("nowait/no_ready", 32'(seen), 32'd0);
      chk("nowait/cs_held", 32'(s_cs), 32'b0100);
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      chk("nowait/rst_cs", 32'(s_cs), 32'd0);
    end
`endif
    run(vecs[1]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
